// File: rtl/usb_pkg.sv
// Shared types and constants for the USB bit-stuffing codec.
package usb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    STUFF  = 2'd2,
    ERR    = 2'd3
  } codec_state_t;

  localparam int MODE_TX     = 0;
  localparam int MODE_RX     = 1;
  localparam int USB_MAX_RUN = 6;

  function automatic int run_cnt_w(input int max_run);
    return $clog2(max_run + 1);
  endfunction

endpackage

// File: rtl/bit_stuff_codec_if.sv
// Serial bit-stream bundle between an upstream bit source and the stuffing codec.
interface bit_stuff_codec_if;

  logic start;
  logic last;
  logic in_valid;
  logic bit_in;
  logic bit_out;
  logic out_valid;
  logic stall;
  logic stuff_err;
  logic done;

  modport master (
    output start, last, in_valid, bit_in,
    input  bit_out, out_valid, stall, stuff_err, done
  );

  modport slave (
    input  start, last, in_valid, bit_in,
    output bit_out, out_valid, stall, stuff_err, done
  );

endinterface

// File: rtl/bit_stuff_codec_ones_run_counter.sv
// Consecutive-ones run counter, saturating at MAX_RUN; clr+inc together loads 1.
// Registered count, flags are combinational from the count; no backpressure.
module ones_run_counter
  import usb_pkg::*;
#(
  parameter int MAX_RUN = USB_MAX_RUN
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic at_max,
  output logic near_max
);

  localparam int CW = run_cnt_w(MAX_RUN);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clr && inc) begin
      r_cnt <= CW'(1);
    end else if (clr) begin
      r_cnt <= '0;
    end else if (inc && (r_cnt != CW'(MAX_RUN))) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign at_max   = (r_cnt == CW'(MAX_RUN));
  assign near_max = (r_cnt == CW'(MAX_RUN - 1));

endmodule

// File: rtl/bit_stuff_codec.sv
// USB bit-stuffing codec: MODE_TX inserts a 0 after MAX_RUN ones (stalling upstream one cycle),
// MODE_RX drops that 0 and flags violations. Output latency 1 cycle; done 1 cycle after last output.
module bit_stuff_codec
  import usb_pkg::*;
#(
  parameter int MAX_RUN = USB_MAX_RUN,
  parameter int MODE    = MODE_TX
) (
  input  logic                clk,
  input  logic                rst,
  bit_stuff_codec_if.slave    bus
);

  localparam bit IS_RX = (MODE == MODE_RX);

  codec_state_t r_state;
  codec_state_t w_state_nxt;

  logic r_bit;
  logic r_vld;
  logic r_err;
  logic r_done;
  logic r_done_pend;
  logic r_stuff_last;

  logic w_bit_nxt;
  logic w_vld_nxt;
  logic w_err_nxt;
  logic w_done_pend_nxt;
  logic w_stuff_last_nxt;
  logic w_inc;
  logic w_clr;
  logic w_at_max;
  logic w_near_max;
  logic w_stall;
  logic w_take;
  logic w_run_near;
  logic w_run_max;

  ones_run_counter #(
    .MAX_RUN (MAX_RUN)
  ) u_run (
    .clk      (clk),
    .rst      (rst),
    .inc      (w_inc),
    .clr      (w_clr),
    .at_max   (w_at_max),
    .near_max (w_near_max)
  );

  assign w_stall = !IS_RX && (r_state == STUFF);
  assign w_take  = bus.in_valid && !w_stall && (bus.start || (r_state == ACTIVE));

  // A start bit sees an empty run regardless of what the counter still holds.
  assign w_run_near = bus.start ? (MAX_RUN == 1) : w_near_max;
  assign w_run_max  = bus.start ? 1'b0 : w_at_max;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_bit_nxt        = r_bit;
    w_vld_nxt        = 1'b0;
    w_err_nxt        = 1'b0;
    w_done_pend_nxt  = 1'b0;
    w_stuff_last_nxt = r_stuff_last;
    w_inc            = 1'b0;
    w_clr            = 1'b0;

    if (w_stall) begin
      // A start arriving during a stuff cycle abandons the stuff; the held bit is taken next cycle.
      if (bus.in_valid && bus.start) begin
        w_clr       = 1'b1;
        w_state_nxt = ACTIVE;
      end else begin
        w_bit_nxt       = 1'b0;
        w_vld_nxt       = 1'b1;
        w_clr           = 1'b1;
        w_state_nxt     = r_stuff_last ? IDLE : ACTIVE;
        w_done_pend_nxt = r_stuff_last;
      end
    end else if (w_take) begin
      w_clr = bus.start || !bus.bit_in;
      if (IS_RX && w_run_max) begin
        w_clr = 1'b1;
        if (bus.bit_in) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = ERR;
        end else begin
          w_state_nxt     = bus.last ? IDLE : ACTIVE;
          w_done_pend_nxt = bus.last;
        end
      end else begin
        w_bit_nxt = bus.bit_in;
        w_vld_nxt = 1'b1;
        w_inc     = bus.bit_in;
        if (!IS_RX && bus.bit_in && w_run_near) begin
          w_state_nxt      = STUFF;
          w_stuff_last_nxt = bus.last;
        end else begin
          w_state_nxt     = bus.last ? IDLE : ACTIVE;
          w_done_pend_nxt = bus.last;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bit        <= 1'b0;
      r_vld        <= 1'b0;
      r_err        <= 1'b0;
      r_done       <= 1'b0;
      r_done_pend  <= 1'b0;
      r_stuff_last <= 1'b0;
    end else begin
      r_bit        <= w_bit_nxt;
      r_vld        <= w_vld_nxt;
      r_err        <= w_err_nxt;
      r_done       <= r_done_pend;
      r_done_pend  <= w_done_pend_nxt;
      r_stuff_last <= w_stuff_last_nxt;
    end
  end

  assign bus.bit_out   = r_bit;
  assign bus.out_valid = r_vld;
  assign bus.stall     = w_stall;
  assign bus.stuff_err = r_err;
  assign bus.done      = r_done;

endmodule

// File: doc/bit_stuff_codec.md
Name: bit_stuff_codec

Overview:
Parametrised bit-stuffing codec for the USB serial path.
- MODE=0 (TX) sits between the bit stream encoder and the NRZI encoder. It inserts a 0 after every MAX_RUN consecutive 1s and back-pressures upstream with stall.
- MODE=1 (RX) sits after the NRZI decoder. It removes the stuffed 0s and flags stuff errors.
- The run length is configurable, and both directions share one state machine and one run counter.

Parameters:
- MAX_RUN, 6: number of consecutive 1s that forces a stuffed 0. Legal range 1..15.
- MODE, 0: 0 = stuff (TX), 1 = unstuff (RX).

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous reset, active-high
- start  input  1  first bit of a packet is on bit_in this cycle (qualified by in_valid)
- last  input  1  final bit of a packet is on bit_in this cycle (qualified by in_valid)
- in_valid  input  1  bit_in is valid
- bit_in  input  1  serial input bit
- bit_out  output  1  serial output bit, registered
- out_valid  output  1  bit_out is a payload or stuffed bit, registered
- stall  output  1  TX: upstream must hold bit_in/last this cycle. RX: tied 0
- stuff_err  output  1  RX: one-cycle pulse on a stuff violation. TX: tied 0
- done  output  1  one-cycle pulse after the final output bit of a packet

Behaviour:
- Reset (async, any time including mid-packet): state=IDLE, run counter=0, and bit_out, out_valid, stuff_err, done all 0. stall=0 follows from state=IDLE.
- Run counter: width $clog2(MAX_RUN+1). It counts consecutive 1s on the output side (TX) or the input side (RX). It clears on any 0, on a stuffed or dropped bit, and on start.
- States:
  - IDLE: waits for start&in_valid.
  - ACTIVE
  - STUFF: TX only.
  - ERR: RX only.
- An input bit is accepted when in_valid & ~stall & state in {IDLE with start, ACTIVE}.
- TX, accepted bit:
  - Next edge: bit_out=bit_in, out_valid=1. Latency 1 cycle.
  - If the bit is a 1 and the counter reaches MAX_RUN, go to STUFF.
- TX, STUFF:
  - stall=1, combinational from state.
  - Next edge: bit_out=0, out_valid=1, counter=0.
  - Then return to ACTIVE, or to IDLE if the triggering bit was last.
  - The upstream bit held during stall is accepted in the following cycle.
- TX, last accepted with no stuff pending: go to IDLE. done=1 on the edge after the last bit's output cycle.
- A trailing stuff is always inserted when last completes a run. done then follows the stuffed 0.
- RX, accepted bit with counter<MAX_RUN: bit_out=bit_in, out_valid=1 next edge. Latency 1.
- RX, counter==MAX_RUN:
  - An accepted 0 is dropped: out_valid=0 next cycle, counter=0.
  - An accepted 1 is a violation: stuff_err=1 for one cycle, out_valid=0, go to ERR.
  - In ERR all input is discarded until the next start.
- in_valid=0 while ACTIVE: out_valid=0 next cycle, and counter and state hold.
- start&last in the same accepted cycle: a 1-bit packet. done follows that bit, or its stuff in TX.
- start while ACTIVE/STUFF/ERR: abort the current packet. Counter is cleared, any pending stuff is discarded, no done is issued for the aborted packet, and the new bit is processed as the first bit.
- Without start, inputs in IDLE are ignored.
- When done fires, out_valid is 0 unless a new packet's first bit was accepted in the previous cycle. Back-to-back packets are allowed.

Decomposition:
- usb_pkg:
  - codec_state_t enum {IDLE, ACTIVE, STUFF, ERR}
  - MODE_TX=0, MODE_RX=1 constants
  - USB_MAX_RUN=6 default
- One sub-module, ones_run_counter (parameter MAX_RUN).
  - Inputs: inc, clr.
  - Output: at_max.
  - Instantiated once.

Test Plan:
1. TX, MAX_RUN=6.
   - Stimulus: start on the first bit; input 0,1,1,0,0 then ten 1s; last on the 15th bit.
   - Required: output 0110011111101111 (16 bits), stall high for exactly 1 cycle after the 6th consecutive 1, done 1 cycle after the final 1.
2. TX, MAX_RUN=6, trailing stuff.
   - Stimulus: six 1s with last on the 6th.
   - Required: output 1111110, done after the 0.
   - Repeat with MAX_RUN=3 and input 1111: required output 11101.
3. RX, MAX_RUN=6.
   - Stimulus: the 16-bit output of scenario 1.
   - Required: the original 15 bits on out_valid cycles, one out_valid=0 gap where the stuffed 0 is dropped, stuff_err never asserted.
4. RX, MAX_RUN=6, violation.
   - Stimulus: start followed by seven consecutive 1s, then further bits.
   - Required: six outputs, then stuff_err pulses once and out_valid stays 0.
   - A following start recovers normal operation.
5. Reset and abort mid-packet.
   - Assert rst while TX is in STUFF: all outputs are 0 the same cycle.
   - Assert start during an ACTIVE packet: no done for the aborted packet, and the counter restarts (six new 1s are needed before the next stuff).
6. in_valid gaps.
   - Stimulus: TX with in_valid toggling every other cycle across a 6-ones run.
   - Required: the stuff still occurs after exactly six 1s, and out_valid mirrors the accepted cycles.
